// File: rtl/mem_ctrl_pkg.sv
// Shared widths and FSM encoding for the mem_ctrl SRAM access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Single-port 16x4 asynchronous SRAM controller: SETUP/STROBE/HOLD access
// sequencing for host requests, plus a self-timed fill of the whole array.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  input  logic [DATA_W-1:0] init_value,
  output logic              init_busy,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              mem_cs_n,
  output logic              mem_we_n
);

  localparam logic [1:0] STROBE_LAST = 2'(STROBE_CYCLES - 1);

  mem_ctrl_state_t   state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        strobe_cnt_q, strobe_cnt_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              fill_q, fill_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req_accept;

  // A same-cycle init_start takes the slot, so ready is withdrawn to keep the
  // valid/ready handshake honest for the losing request.
  assign req_ready  = (state_q == IDLE) && !fill_q && !init_start;
  assign req_accept = req_valid && req_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strobe_cnt_d = strobe_cnt_q;
    fill_addr_d  = fill_addr_q;
    fill_d       = fill_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (init_start && !fill_q) begin
          state_d     = SETUP;
          fill_d      = 1'b1;
          fill_addr_d = '0;
          we_d        = 1'b1;
          addr_d      = '0;
          data_d      = init_value;
        end else if (req_accept) begin
          state_d = SETUP;
          we_d    = req_we;
          addr_d  = req_addr;
          data_d  = req_wdata;
        end
      end
      SETUP: begin
        state_d      = STROBE;
        strobe_cnt_d = '0;
      end
      STROBE: begin
        if (strobe_cnt_q == STROBE_LAST) begin
          state_d = HOLD;
          if (!we_q) rdata_d = mem_q;
        end else begin
          strobe_cnt_d = strobe_cnt_q + 2'd1;
        end
      end
      HOLD: begin
        if (fill_q) begin
          // The fill ends when the word counter wraps back to address 0.
          fill_addr_d = fill_addr_q + 1'b1;
          if (fill_addr_d == '0) begin
            state_d = IDLE;
            fill_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
            addr_d  = fill_addr_d;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      strobe_cnt_q <= '0;
      fill_addr_q  <= '0;
      fill_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strobe_cnt_q <= strobe_cnt_d;
      fill_addr_q  <= fill_addr_d;
      fill_q       <= fill_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

  // Pin strobes decode straight from state so they can only assert in STROBE.
  assign mem_a     = addr_q;
  assign mem_d     = data_q;
  assign mem_cs_n  = (state_q != STROBE);
  assign mem_we_n  = !((state_q == STROBE) && we_q);
  assign rsp_valid = (state_q == HOLD) && !we_q;
  assign rsp_rdata = rdata_q;
  assign init_busy = fill_q;
  assign init_done = done_q;

endmodule
